// File: rtl/divisor_control_pkg.sv
// Shared definitions for the restoring-divider sequencer and the quotient output stage.
package divisor_control_pkg;

  // Quotient-bit commands, also decoded by the quotient output shift register
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_0    = 2'b10;
  localparam logic [1:0] CMD_1    = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/divisor_control_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, conditionally subtract.
module divisor_step #(
  parameter int N = 8
) (
  input  logic [N:0]   r_i,
  input  logic         bit_i,
  input  logic [N-1:0] v_i,
  output logic [N:0]   r_o,
  output logic         q_o
);

  logic [N:0] t;

  assign t   = {r_i[N-1:0], bit_i};
  // r_i[N] is always 0 in normal operation; folding it in keeps the compare safe if it ever is not
  assign q_o = r_i[N] | (t >= {1'b0, v_i});
  assign r_o = q_o ? (t - {1'b0, v_i}) : t;

endmodule

// File: rtl/divisor_control.sv
// Sequencer for an N-bit restoring divider: one quotient bit per clock, MSB first,
// with a quotient-bit command per iteration and a one-cycle done pulse on completion.
module divisor_control
  import divisor_control_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [1:0]   o_a,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  state_t         state_q, state_d;
  logic [N-1:0]   d_q, d_d, v_q, v_d, q_q, q_d;
  logic [N-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic [N:0]     r_q, r_d, r_next;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic           q_bit;

  divisor_step #(.N(N)) u_step (
    .r_i   (r_q),
    .bit_i (d_q[N-1]),
    .v_i   (v_q),
    .r_o   (r_next),
    .q_o   (q_bit)
  );

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    o_a     = CMD_NONE;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d     = dividend;
          v_d     = divisor;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        r_d   = '0;
        q_d   = '0;
        cnt_d = CW'(N);
        if (v_q == '0) begin
          quot_d  = '1;
          rem_d   = d_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        o_a   = q_bit ? CMD_1 : CMD_0;
        r_d   = r_next;
        d_d   = {d_q[N-2:0], 1'b0};
        q_d   = {q_q[N-2:0], q_bit};
        cnt_d = cnt_q - CW'(1);
        // Last iteration: publish results so they are valid alongside done
        if (cnt_q == CW'(1)) begin
          quot_d  = {q_q[N-2:0], q_bit};
          rem_d   = r_next[N-1:0];
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      v_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
